// File: rtl/ni_inject_queue_if.sv
// Handshake bundle between the core/NI, the injection queue and the router local input.
// master: the core + router side that drives core_valid/core_flit/slot_free.
// slave: the queue itself, which drives core_ready, inj_flit, occupancy and starve_flag.
interface ni_inject_queue_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   logic                      core_valid;
   logic [DATA_W-1:0]         core_flit;
   logic                      core_ready;
   logic                      slot_free;
   logic [DATA_W-1:0]         inj_flit;
   logic [$clog2(DEPTH):0]    occupancy;
   logic                      starve_flag;

   modport master (
      output core_valid,
      output core_flit,
      output slot_free,
      input  core_ready,
      input  inj_flit,
      input  occupancy,
      input  starve_flag
   );

   modport slave (
      input  core_valid,
      input  core_flit,
      input  slot_free,
      output core_ready,
      output inj_flit,
      output occupancy,
      output starve_flag
   );
endinterface

// File: rtl/ni_inject_queue.sv
// Local-port injection FIFO: stamps each core flit with an age timestamp and presents the head to the router.
// Latency: a flit pushed in cycle N is first visible on inj_flit in cycle N+1 (no bypass path).
// Backpressure: core_ready drops while DEPTH entries are held; the head pops only when slot_free is high.
// Optional starvation counter/flag is built only when INJ_STARVE_CNT_EN is defined.
module ni_inject_queue #(
   parameter int DATA_W    = 32,
   parameter int TIME_W    = 8,
   parameter int DEPTH     = 4,
   parameter int STARVE_TH = 16,
   parameter int VALID_POS = DATA_W - 1,
   parameter int TIME_POS  = 0
) (
   input  logic                clk,
   input  logic                n_rst,
   ni_inject_queue_if.slave    bus_if
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   // Queue state
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q,    occ_d;
   logic [TIME_W-1:0] ts_q,     ts_d;

   logic              core_ready;
   logic              not_empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_dat;

   // Handshake qualifiers are derived from registered occupancy only, so
   // core_ready and inj_flit never depend combinationally on the inputs.
   assign core_ready = (occ_q != OCC_FULL);
   assign not_empty  = (occ_q != '0);
   assign push       = bus_if.core_valid && core_ready;
   assign pop        = bus_if.slot_free  && not_empty;

   // Stamp the incoming flit: TIME takes the current counter, VALID is forced high.
   always_comb begin
      push_dat                        = bus_if.core_flit;
      push_dat[TIME_POS +: TIME_W]    = ts_q;
      push_dat[VALID_POS]             = 1'b1;
   end

   // Next-state for pointers, occupancy and the free-running timestamp.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      ts_d     = ts_q + TIME_W'(1);
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control registers with synchronous active-low reset; a reset drops every queued flit.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ts_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ts_q     <= ts_d;
      end
   end

   // Storage array; contents are don't-care until written, occupancy gates the output.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   assign bus_if.core_ready = core_ready;
   assign bus_if.occupancy  = occ_q;
   assign bus_if.inj_flit   = not_empty ? mem_q[rd_ptr_q] : '0;

`ifdef INJ_STARVE_CNT_EN
   // Consecutive cycles the head has been held back by the router.
   logic [7:0] starve_cnt_q, starve_cnt_d;
   logic       starve_flag_q, starve_flag_d;

   // Count blocked cycles, saturating at 255; any pop or an empty queue restarts the count.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!not_empty || pop) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != 8'hFF) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
      starve_flag_d = (32'(starve_cnt_d) >= STARVE_TH);
   end

   // Register the counter and the threshold compare so the flag is glitch-free.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         starve_cnt_q  <= '0;
         starve_flag_q <= 1'b0;
      end else begin
         starve_cnt_q  <= starve_cnt_d;
         starve_flag_q <= starve_flag_d;
      end
   end

   assign bus_if.starve_flag = starve_flag_q;
`else
   assign bus_if.starve_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ni_inject_queue.sv
// Bench for ni_inject_queue: directed scenarios plus randomized traffic against a queue-based model.
// The model holds stamped flits in a SystemVerilog queue and a plain integer timestamp.
// Outputs are compared every cycle on the falling edge; inputs change on the falling edge too.
module tb_ni_inject_queue;
   localparam int DATA_W    = 32;
   localparam int TIME_W    = 8;
   localparam int DEPTH     = 4;
   localparam int STARVE_TH = 16;
`ifdef INJ_STARVE_CNT_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic clk;
   logic n_rst;

   ni_inject_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   ni_inject_queue #(
      .DATA_W    (DATA_W),
      .TIME_W    (TIME_W),
      .DEPTH     (DEPTH),
      .STARVE_TH (STARVE_TH),
      .VALID_POS (31),
      .TIME_POS  (0)
   ) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .bus_if (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DATA_W-1:0] m_q[$];
   int                m_ts  = 0;
   int                m_blk = 0;
   bit                m_pop, m_push;

   function automatic logic [31:0] stamp(input logic [31:0] f, input int ts);
      logic [31:0] r;
      r       = f;
      r[7:0]  = ts[7:0];
      r[31]   = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      if (!n_rst) begin
         m_q.delete();
         m_ts  = 0;
         m_blk = 0;
      end else begin
         m_pop  = (m_q.size() > 0) && bus.slot_free;
         m_push = bus.core_valid && (m_q.size() < DEPTH);
         if (m_q.size() == 0 || m_pop) m_blk = 0;
         else if (m_blk < 255)         m_blk = m_blk + 1;
         if (m_pop)  void'(m_q.pop_front());
         if (m_push) m_q.push_back(stamp(bus.core_flit, m_ts));
         m_ts = (m_ts + 1) % (1 << TIME_W);
      end
   end

   function automatic logic [31:0] exp_inj();
      return (m_q.size() > 0) ? m_q[0] : 32'h0;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("inj_flit",    bus.inj_flit,    exp_inj());
         check("occupancy",   bus.occupancy,   64'(m_q.size()));
         check("core_ready",  bus.core_ready,  64'(m_q.size() != DEPTH));
         check("starve_flag", bus.starve_flag, 64'(STARVE_ON && (m_blk >= STARVE_TH)));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] exp_ord [5];
   logic [31:0] f;

   initial begin
      n_rst          = 1'b0;
      bus.core_valid = 1'b0;
      bus.core_flit  = '0;
      bus.slot_free  = 1'b0;

      // 1: reset held for three cycles
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      check("rst_inj",   bus.inj_flit,   0);
      check("rst_occ",   bus.occupancy,  0);
      check("rst_ready", bus.core_ready, 1);
      n_rst = 1'b1;

      // 2: single flit pushed at ts=5, popped next cycle
      for (int i = 0; i < 20 && m_ts != 5; i++) tick();
      check("t2_ts", 64'(m_ts), 5);
      bus.core_valid = 1'b1;
      bus.core_flit  = 32'h0ABC_DE77;
      tick();
      bus.core_valid = 1'b0;
      bus.slot_free  = 1'b1;
      check("t2_inj", bus.inj_flit, 32'h8ABC_DE05);
      check("t2_occ", bus.occupancy, 1);
      tick();
      check("t2_empty_inj", bus.inj_flit, 0);
      check("t2_empty_occ", bus.occupancy, 0);
      bus.slot_free = 1'b0;

      // 3: five back-to-back pushes with the router blocked; four are accepted
      for (int i = 0; i < 5; i++) begin
         f = $urandom;
         exp_ord[i]     = stamp(f, m_ts);
         bus.core_valid = 1'b1;
         bus.core_flit  = f;
         tick();
      end
      check("t3_occ",   bus.occupancy, 4);
      check("t3_ready", bus.core_ready, 0);
      check("t3_head",  bus.inj_flit, exp_ord[0]);

      // 4: full with a push offered and a pop granted in the same cycle
      bus.slot_free = 1'b1;
      check("t4_ready_full", bus.core_ready, 0);
      check("t4_occ_full",   bus.occupancy, 4);
      tick();
      bus.core_valid = 1'b0;
      check("t4_occ_after",  bus.occupancy, 3);
      check("t4_head_adv",   bus.inj_flit, exp_ord[1]);
      tick();
      check("t4_order2", bus.inj_flit, exp_ord[2]);
      tick();
      check("t4_order3", bus.inj_flit, exp_ord[3]);
      tick();
      check("t4_drained", bus.occupancy, 0);
      bus.slot_free = 1'b0;

      // 5: timestamp wrap from 255 to 0
      for (int i = 0; i < 300 && m_ts != 255; i++) tick();
      check("t5_ts", 64'(m_ts), 255);
      bus.core_valid = 1'b1;
      bus.core_flit  = 32'h1111_1111;
      tick();
      bus.core_flit  = 32'h2222_2222;
      tick();
      bus.core_valid = 1'b0;
      check("t5_occ",    bus.occupancy, 2);
      check("t5_time0",  bus.inj_flit[7:0], 8'd255);
      bus.slot_free = 1'b1;
      tick();
      check("t5_time1",  bus.inj_flit[7:0], 8'd0);
      check("t5_flit1",  bus.inj_flit, 32'hA222_2200);
      tick();
      bus.slot_free = 1'b0;

      // 6: head blocked for 16 cycles
      bus.core_valid = 1'b1;
      bus.core_flit  = $urandom;
      tick();
      bus.core_valid = 1'b0;
      repeat (15) tick();
      check("t6_flag_early", bus.starve_flag, 0);
      tick();
      check("t6_flag_set", bus.starve_flag, 64'(STARVE_ON));
      bus.slot_free = 1'b1;
      tick();
      check("t6_flag_clr", bus.starve_flag, 0);
      check("t6_occ",      bus.occupancy, 0);

      // Randomized traffic with occasional mid-operation resets and long stalls
      for (int i = 0; i < 3000; i++) begin
         bus.core_valid = ($urandom_range(0, 3) != 0);
         bus.core_flit  = $urandom;
         if ((i / 200) % 2 == 1) bus.slot_free = ($urandom_range(0, 15) == 0);
         else                    bus.slot_free = ($urandom_range(0, 2) == 0);
         n_rst = ($urandom_range(0, 149) != 0);
         tick();
         if (!n_rst) begin
            check("rnd_rst_inj", bus.inj_flit, 0);
            n_rst = 1'b1;
         end
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
